// File: rtl/adc_pkg.sv
// Shared types and constants for the LTC2308-style ADC responder.
package adc_pkg;

   // Config word as shifted in on DIN, MSB first: {S/D, O/S, S1, S0, UNI, SLP}.
   typedef struct packed {
      logic sd;
      logic os;
      logic s1;
      logic s0;
      logic uni;
      logic slp;
   } adc_cfg_t;

   typedef enum logic [1:0] {READY, SHIFT, CONVERT} resp_state_t;

   localparam logic [5:0]  CFG_RESET = 6'b100010;
   localparam logic [11:0] MIDSCALE  = 12'h800;

   // Single-ended channel number as encoded by the LTC2308 mux bits.
   function automatic logic [2:0] cfg_channel(input adc_cfg_t cfg);
      return {cfg.s1, cfg.s0, cfg.os};
   endfunction

endpackage

// File: rtl/adc_resp_sync.sv
// Two-flop synchronizer plus registered edge detector for CS_N and SCLK.
// DIN is only synchronized; it is sampled by the consumer on the SCLK rise pulse.
module adc_resp_sync (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic cs_n_i,
   input  logic sclk_i,
   input  logic din_i,
   output logic cs_n_o,
   output logic cs_rise_o,
   output logic cs_fall_o,
   output logic sclk_o,
   output logic sclk_rise_o,
   output logic sclk_fall_o,
   output logic din_o
);

   // Bit 1 is CS_N, bit 0 is SCLK; idle levels are CS_N high, SCLK low.
   localparam logic [1:0] IdleLvl = 2'b10;

   logic [1:0] meta_q, sync_q, prev_q, rise_q, fall_q;
   logic       din_meta_q, din_sync_q;

   // Synchronize pins, then register the edge pulses so events lag the pins by 3 cycles.
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         meta_q     <= IdleLvl;
         sync_q     <= IdleLvl;
         prev_q     <= IdleLvl;
         rise_q     <= '0;
         fall_q     <= '0;
         din_meta_q <= 1'b0;
         din_sync_q <= 1'b0;
      end else begin
         meta_q     <= {cs_n_i, sclk_i};
         sync_q     <= meta_q;
         prev_q     <= sync_q;
         rise_q     <= sync_q & ~prev_q;
         fall_q     <= ~sync_q & prev_q;
         din_meta_q <= din_i;
         din_sync_q <= din_meta_q;
      end
   end

   // prev_q holds the level that matches the registered pulses.
   assign cs_n_o      = prev_q[1];
   assign cs_rise_o   = rise_q[1];
   assign cs_fall_o   = fall_q[1];
   assign sclk_o      = prev_q[0];
   assign sclk_rise_o = rise_q[0];
   assign sclk_fall_o = fall_q[0];
   assign din_o       = din_sync_q;

endmodule

// File: rtl/adc_responder.sv
// Responder-side model of an LTC2308-style SPI ADC.
// Optional feature: define ADC_RESP_RAMP_EN to return a synthetic ramp instead of ext_sample.
module adc_responder
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W      = 12,
   parameter int unsigned CONV_CYCLES = 80,
   parameter int unsigned RAMP_STEP   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ADC_CS_N,
   input  logic              ADC_SCLK,
   input  logic              ADC_DIN,
   output logic              ADC_DOUT,
   input  logic [DATA_W-1:0] ext_sample,
   output logic              busy,
   output logic              frame_done,
   output logic [5:0]        cfg_word,
   output logic              protocol_err
);

   localparam int unsigned       CntW     = $clog2(CONV_CYCLES);
   localparam logic [CntW-1:0]   CntLast  = CntW'(CONV_CYCLES - 1);
   localparam logic [DATA_W-1:0] MidScale = DATA_W'(MIDSCALE);

   logic cs_lvl, cs_rise, cs_fall, sclk_lvl_unused, sclk_rise, sclk_fall, din;
   logic sclk_rise_v, sclk_fall_v;

   resp_state_t       state_q, state_d;
   adc_cfg_t          cfg_q, cfg_d;
   logic [5:0]        cfg_sr_q, cfg_sr_d;
   logic [2:0]        rise_cnt_q, rise_cnt_d;
   logic [DATA_W-1:0] dout_sr_q, dout_sr_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CntW-1:0]   conv_cnt_q, conv_cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] raw, conv_result;

`ifdef ADC_RESP_RAMP_EN
   logic [DATA_W-1:0] ramp_q, ramp_d;
   logic              ext_unused;
   assign ext_unused = ^ext_sample;
`else
   logic [DATA_W-1:0] step_unused;
   assign step_unused = DATA_W'(RAMP_STEP);
`endif

   adc_resp_sync u_sync (
      .clk_i       (clk),
      .reset_ni    (reset),
      .cs_n_i      (ADC_CS_N),
      .sclk_i      (ADC_SCLK),
      .din_i       (ADC_DIN),
      .cs_n_o      (cs_lvl),
      .cs_rise_o   (cs_rise),
      .cs_fall_o   (cs_fall),
      .sclk_o      (sclk_lvl_unused),
      .sclk_rise_o (sclk_rise),
      .sclk_fall_o (sclk_fall),
      .din_o       (din)
   );

   // A CS_N edge takes priority; a coincident SCLK edge is dropped.
   assign sclk_rise_v = sclk_rise & ~(cs_rise | cs_fall);
   assign sclk_fall_v = sclk_fall & ~(cs_rise | cs_fall);

   // Sample value for the conversion that is finishing, from the latched config.
   always_comb begin
      raw = MidScale;
      if (cfg_q.sd) begin
`ifdef ADC_RESP_RAMP_EN
         raw = ramp_q + (DATA_W'(cfg_channel(cfg_q)) << (DATA_W - 3));
`else
         raw = ext_sample;
`endif
      end
      conv_result = cfg_q.uni ? raw : (raw ^ MidScale);
   end

   // Frame/convert sequencing and next-state for all datapath registers.
   always_comb begin
      state_d      = state_q;
      cfg_d        = cfg_q;
      cfg_sr_d     = cfg_sr_q;
      rise_cnt_d   = rise_cnt_q;
      dout_sr_d    = dout_sr_q;
      result_d     = result_q;
      conv_cnt_d   = conv_cnt_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
`ifdef ADC_RESP_RAMP_EN
      ramp_d       = ramp_q;
`endif

      if ((sclk_rise_v || sclk_fall_v) && cs_lvl) begin
         err_d = 1'b1;
      end

      case (state_q)
         READY: begin
            if (cs_fall) begin
               state_d    = SHIFT;
               dout_sr_d  = result_q;
               rise_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               state_d      = CONVERT;
               frame_done_d = 1'b1;
               conv_cnt_d   = '0;
               dout_sr_d    = '0;
               if (rise_cnt_q == 3'd6) begin
                  cfg_d = adc_cfg_t'(cfg_sr_q);
               end
            end else begin
               // Only the first six DIN bits form the config word.
               if (sclk_rise_v && (rise_cnt_q < 3'd6)) begin
                  cfg_sr_d   = {cfg_sr_q[4:0], din};
                  rise_cnt_d = rise_cnt_q + 3'd1;
               end
               // Zero fill leaves DOUT low after the last result bit.
               if (sclk_fall_v) begin
                  dout_sr_d = dout_sr_q << 1;
               end
            end
         end
         CONVERT: begin
            if (cs_fall) begin
               // Aborted conversion: replay the previous result, leave the ramp alone.
               err_d      = 1'b1;
               state_d    = SHIFT;
               dout_sr_d  = result_q;
               rise_cnt_d = '0;
            end else if (conv_cnt_q == CntLast) begin
               state_d  = READY;
               result_d = conv_result;
`ifdef ADC_RESP_RAMP_EN
               ramp_d   = ramp_q + DATA_W'(RAMP_STEP);
`endif
            end else begin
               conv_cnt_d = conv_cnt_q + CntW'(1);
            end
         end
         default: state_d = READY;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= READY;
         cfg_q        <= adc_cfg_t'(CFG_RESET);
         cfg_sr_q     <= '0;
         rise_cnt_q   <= '0;
         dout_sr_q    <= '0;
         result_q     <= '0;
         conv_cnt_q   <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef ADC_RESP_RAMP_EN
         ramp_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         cfg_sr_q     <= cfg_sr_d;
         rise_cnt_q   <= rise_cnt_d;
         dout_sr_q    <= dout_sr_d;
         result_q     <= result_d;
         conv_cnt_q   <= conv_cnt_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
`ifdef ADC_RESP_RAMP_EN
         ramp_q       <= ramp_d;
`endif
      end
   end

   assign ADC_DOUT     = dout_sr_q[DATA_W-1];
   assign busy         = (state_q == CONVERT);
   assign frame_done   = frame_done_q;
   assign cfg_word     = cfg_q;
   assign protocol_err = err_q;

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: the stimulus side queues the expected DOUT bits of
// each frame, a monitor captures DOUT at every SCLK rise and checks on frame_done.
module tb_adc_responder;

   localparam int unsigned ConvCycles = 80;

`ifdef ADC_RESP_RAMP_EN
   localparam logic [11:0] R1 = 12'h000, R3 = 12'h020, R4 = 12'h430;
   localparam logic [11:0] R5 = 12'h440, R7 = 12'h050, R8 = 12'h860;
`else
   localparam logic [11:0] R1 = 12'h123, R3 = 12'hABC, R4 = 12'h3C5;
   localparam logic [11:0] R5 = 12'h7FF, R7 = 12'h0F0, R8 = 12'h8F0;
`endif

   typedef struct {
      logic [13:0] bits;
      int          n;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ADC_CS_N = 1'b1;
   logic        ADC_SCLK = 1'b0;
   logic        ADC_DIN = 1'b0;
   logic        ADC_DOUT;
   logic [11:0] ext_sample = 12'h000;
   logic        busy;
   logic        frame_done;
   logic [5:0]  cfg_word;
   logic        protocol_err;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   adc_responder dut (
      .clk          (clk),
      .reset        (reset),
      .ADC_CS_N     (ADC_CS_N),
      .ADC_SCLK     (ADC_SCLK),
      .ADC_DIN      (ADC_DIN),
      .ADC_DOUT     (ADC_DOUT),
      .ext_sample   (ext_sample),
      .busy         (busy),
      .frame_done   (frame_done),
      .cfg_word     (cfg_word),
      .protocol_err (protocol_err)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Queue the expected capture, then drive one frame with the config MSB first.
   task automatic do_frame(input logic [5:0] cfg, input int nclk, input logic [11:0] word,
                           input string name);
      exp_t        e;
      logic [13:0] full;
      full   = {word, 2'b00};
      e.bits = full >> (14 - nclk);
      e.n    = nclk;
      e.name = name;
      exp_q.push_back(e);
      ADC_CS_N = 1'b0;
      wait_cyc(6);
      for (int i = 0; i < nclk; i++) begin
         ADC_DIN = (i < 6) ? cfg[5-i] : 1'b0;
         wait_cyc(3);
         ADC_SCLK = 1'b1;
         wait_cyc(6);
         ADC_SCLK = 1'b0;
         wait_cyc(3);
      end
      ADC_DIN = 1'b0;
      wait_cyc(4);
      ADC_CS_N = 1'b1;
   endtask

   task automatic wait_busy_rise();
      int k = 0;
      while (!busy && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("busy_rise", 32'(busy), 32'd1);
   endtask

   // Wait through a whole conversion and check how long busy stayed high.
   task automatic wait_conv(input string name);
      int n = 0;
      wait_busy_rise();
      while (busy && n < 300) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(ConvCycles));
      @(posedge clk);
      #1;
   endtask

   // Monitor: capture DOUT at each SCLK rise inside a frame, compare on frame_done.
   initial begin
      logic        sclk_prev;
      logic        cs_prev;
      logic [13:0] cap;
      int          ncap;
      exp_t        e;
      sclk_prev = 1'b0;
      cs_prev   = 1'b1;
      cap       = '0;
      ncap      = 0;
      forever begin
         @(negedge clk);
         if (cs_prev && !ADC_CS_N) begin
            cap  = '0;
            ncap = 0;
         end
         if (!ADC_CS_N && ADC_SCLK && !sclk_prev && ncap < 14) begin
            cap = {cap[12:0], ADC_DOUT};
            ncap++;
         end
         if (frame_done) begin
            check("frame_done_with_busy", 32'(busy), 32'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL frame_done_unexpected: got pulse expected none");
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_nbits"}, 32'(ncap), 32'(e.n));
               check({e.name, "_dout"}, 32'(cap), 32'(e.bits));
            end
         end
         sclk_prev = ADC_SCLK;
         cs_prev   = ADC_CS_N;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      wait_cyc(5);
      reset = 1'b1;
      wait_cyc(2);
      check("rst_dout", 32'(ADC_DOUT), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_err", 32'(protocol_err), 32'd0);
      check("rst_cfg", 32'(cfg_word), 32'h22);

      // First frame after reset shifts out the zero reset result.
      ext_sample = 12'h123;
      do_frame(6'b100010, 14, 12'h000, "f1_reset_result");
      wait_conv("f1_busy_len");
      check("f1_cfg", 32'(cfg_word), 32'h22);

      // Differential bipolar: midscale XOR midscale.
      do_frame(6'b000000, 14, R1, "f2");
      wait_conv("f2_busy_len");
      check("f2_cfg", 32'(cfg_word), 32'h00);

      ext_sample = 12'hABC;
      do_frame(6'b100010, 14, 12'h000, "f3_diff_bipolar");
      wait_conv("f3_busy_len");

      ext_sample = 12'h3C5;
      do_frame(6'b100110, 14, R3, "f4");
      wait_conv("f4_busy_len");
      check("f4_cfg", 32'(cfg_word), 32'h26);

      ext_sample = 12'h7FF;
      do_frame(6'b100110, 14, R4, "f5");
      wait_conv("f5_busy_len");
      check("f5_err_clean", 32'(protocol_err), 32'd0);

      // Start a unipolar-off conversion, then abort it 20 cycles in.
      do_frame(6'b100000, 14, R5, "f6");
      wait_busy_rise();
      wait_cyc(20);
      ext_sample = 12'h0F0;
      do_frame(6'b100010, 14, R5, "f6_abort_replay");
      wait_conv("abort_busy_len");
      check("abort_err", 32'(protocol_err), 32'd1);

      // Shows the aborted conversion did not advance the ramp.
      do_frame(6'b100000, 14, R7, "f7");
      wait_conv("f7_busy_len");

      // Short frame keeps the previous config.
      do_frame(6'b011111, 4, R8, "f8_short");
      wait_conv("f8_busy_len");
      check("short_cfg_held", 32'(cfg_word), 32'h20);

      // Reset in the middle of a frame: no frame_done, everything back to reset state.
      ADC_CS_N = 1'b0;
      wait_cyc(6);
      for (int i = 0; i < 3; i++) begin
         ADC_DIN = 1'b1;
         wait_cyc(3);
         ADC_SCLK = 1'b1;
         wait_cyc(6);
         ADC_SCLK = 1'b0;
         wait_cyc(3);
      end
      reset    = 1'b0;
      ADC_CS_N = 1'b1;
      ADC_DIN  = 1'b0;
      wait_cyc(4);
      reset = 1'b1;
      wait_cyc(4);
      check("mrst_dout", 32'(ADC_DOUT), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_err", 32'(protocol_err), 32'd0);
      check("mrst_cfg", 32'(cfg_word), 32'h22);

      // SCLK activity with CS_N high is a violation and otherwise ignored.
      ADC_SCLK = 1'b1;
      wait_cyc(6);
      ADC_SCLK = 1'b0;
      wait_cyc(6);
      check("idle_sclk_err", 32'(protocol_err), 32'd1);
      check("idle_sclk_cfg", 32'(cfg_word), 32'h22);
      check("idle_sclk_busy", 32'(busy), 32'd0);

      do_frame(6'b100010, 14, 12'h000, "f10_after_reset");
      wait_conv("f10_busy_len");
      wait_cyc(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/adc_responder.md
# adc_responder

Synthesizable model of the LTC2308-style SPI ADC that sits on the `ADC_*` pins, i.e. the responder end of the interface the scope's ADC controller drives. It decodes the controller's CONVST/SCLK/DIN traffic, emulates conversion time, and returns 12-bit samples on `ADC_DOUT`. It is used in place of the physical ADC for closed-loop simulation and on-board self-test of the capture and VGA path. All logic runs on one clock; the SPI inputs are oversampled.

## Interface

- `DATA_W`, 12, sample width (MSB-first on `ADC_DOUT`).
- `CONV_CYCLES`, 80, emulated conversion time in `clk` cycles (1.6 µs at 50 MHz).
- `RAMP_STEP`, 16, ramp increment per completed conversion.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  synchronous, active-low reset.
- `ADC_CS_N`  in  1  CONVST from controller. Rising edge starts a conversion; low level enables the shift frame.
- `ADC_SCLK`  in  1  serial clock from controller.
- `ADC_DIN`  in  1  config bit from controller, sampled on SCLK rising edge.
- `ADC_DOUT`  out  DATA_W→1  serial result, updated after SCLK falling edge.
- `ext_sample`  in  12  external sample source (used when `ADC_RESP_RAMP_EN` is undefined).
- `busy`  out  1  conversion in progress.
- `frame_done`  out  1  one-cycle pulse on each CS_N rising edge that ends a shift frame.
- `cfg_word`  out  6  last complete config word {S/D, O/S, S1, S0, UNI, SLP}.
- `protocol_err`  out  1  sticky violation flag; cleared only by reset.

## Operation

- SPI inputs pass through a 2-FF synchronizer, then a 1-FF edge detector. Required input timing: SCLK high and low each ≥ 4 `clk` cycles.
- The FSM has three states:
  - `READY`: CS_N is high and the result is valid. CS_N falling moves to `SHIFT`.
  - `SHIFT`: CS_N is low. Each SCLK rise shifts `ADC_DIN` into the config shift register. Each SCLK fall advances `ADC_DOUT` to the next bit. CS_N rising moves to `CONVERT`, pulses `frame_done`, and latches the config if exactly 6 or more rising edges were seen; otherwise the config is unchanged.
  - `CONVERT`: `busy` is high and a counter runs `CONV_CYCLES`. At terminal count the result register loads and the state moves to `READY`.
- Frame data:
  - On entering `SHIFT`, `ADC_DOUT` presents result[11] immediately.
  - After the 12th falling edge, and for all further edges, `ADC_DOUT` is 0.
- Pipelining:
  - The config latched at the end of frame N selects the conversion that starts at that same CS_N rising edge.
  - That result is shifted out in frame N+1.
- Result computation:
  - Single-ended (S/D=1): channel = {S1, S0, O/S}.
  - Differential (S/D=0): raw = 12'h800.
  - UNI=1: result = raw. UNI=0: result = raw ^ 12'h800 (two's-complement offset).
  - SLP is stored only.
- Violations set `protocol_err`:
  - CS_N falls during `CONVERT`: the state is forced to `SHIFT` and the previous result is shifted out; the aborted conversion does not update the ramp.
  - SCLK edge seen while CS_N is high: the edge is ignored.
- Reset values:
  - State is `READY`, result = 0, `cfg_word` = 6'b100010 (ch0, single-ended, unipolar).
  - `ADC_DOUT`, `busy`, `frame_done`, and `protocol_err` are 0; the ramp base is 0.
  - Reset mid-frame or mid-conversion takes effect on the next `clk` edge and discards the frame.

## Timing

- Input to internal event latency is 3 `clk` cycles (2 sync + 1 edge).
- `ADC_DOUT` is registered. It changes 4 cycles after the pin-level SCLK fall, and 4 cycles after the CS_N fall for the first bit.
- `busy` rises 4 cycles after the CS_N pin rise and stays high for `CONV_CYCLES` cycles.
- `frame_done` is asserted in the same cycle that `busy` rises.
- If a CS_N edge and an SCLK edge are detected in the same cycle, the CS_N edge wins and the SCLK edge is dropped.

## Configuration

- `ADC_RESP_RAMP_EN` defined:
  - raw = (ramp_base + channel×512) mod 4096.
  - ramp_base += `RAMP_STEP` (wrapping at 4096) on each completed conversion.
  - `ext_sample` is ignored.
- `ADC_RESP_RAMP_EN` undefined:
  - For single-ended configs, raw = `ext_sample` registered at conversion end, with the channel ignored.
  - Differential still returns 12'h800.
  - No ramp logic is synthesized.

## Structure

- `adc_pkg` holds:
  - the `adc_cfg_t` packed struct for the 6 config bits;
  - the `resp_state_t` enum {READY, SHIFT, CONVERT};
  - the constants `CFG_RESET` = 6'b100010 and `MIDSCALE` = 12'h800.
- One sub-module, `adc_resp_sync`: the 2-FF synchronizer plus edge detector for CS_N and SCLK. It outputs the level, rise pulse and fall pulse for each, and passes DIN through synchronized only.

## Test plan

- **Reset then first frame.** Stimulus: release reset, run one frame with DIN=100010 and 12 SCLKs. Required: DOUT bits all 0, `frame_done` pulses once, then `busy` is high for 80 cycles.
- **Ramp.** Stimulus: `ADC_RESP_RAMP_EN` defined, DIN selecting ch2 (100110 → S1=0, S0=1, O/S=0) on frames 1–3. Required: frame 2 returns 0x410 and frame 3 returns 0x420.
- **Bipolar and differential.** Stimulus: config 000000. Required: the next frame returns 0x000 (0x800 ^ 0x800).
- **External source.** Stimulus: macro undefined, `ext_sample` = 0xABC, config 100010. Required: the next frame shifts out 1010_1011_1100 followed by trailing zeros.
- **Early CS_N.** Stimulus: CS_N falls 20 cycles into `CONVERT`. Required: `protocol_err` = 1, the previous result is shifted out, the ramp base is unchanged.
- **Short frame and mid-frame reset.** Stimulus: a frame with 4 SCLKs. Required: `cfg_word` is held. Then reset during a frame. Required: DOUT = 0, state is `READY`, `protocol_err` is cleared.
